// File: rtl/rf_wb_pkg.sv
// Shared sizes and priority-state encoding for the register-file writeback path.
package rf_wb_pkg;
  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 16;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_state_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester arbiter: combinational grants, registered priority state.
module rr_arbiter_2
  import rf_wb_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  prio_state_t state;

  // Grants are masked by reset so no handshake can be seen while reset is held.
  always_comb begin
    gnt_a = enable && !reset && req_a && (!req_b || (state == PRIO_A));
    gnt_b = enable && !reset && req_b && (!req_a || (state == PRIO_B));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PRIO_A;
    end else if (!RR_ENABLE) begin
      state <= PRIO_A;
    end else if (gnt_a) begin
      state <= PRIO_B;
    end else if (gnt_b) begin
      state <= PRIO_A;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between ALU and load results, with a pending-write scoreboard.
module regfile_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_enable,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [REG_IDX_W-1:0] a_dest,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [REG_IDX_W-1:0] b_dest,
  input  logic [DATA_W-1:0]    b_data,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_dest,
  output logic [DATA_W-1:0]    rf_port_c,
  output logic [REG_IDX_W-1:0] rf_dest,
  output logic                 rf_load_enable,
  output logic [NUM_REGS-1:0]  busy
);

  localparam logic [NUM_REGS-1:0] IDX_ONE = NUM_REGS'(1);

  logic                 wr_vld_p0;
  logic [REG_IDX_W-1:0] wr_dest_p0;
  logic [DATA_W-1:0]    wr_data_p0;
  logic [NUM_REGS-1:0]  clr_mask_p0;
  logic [NUM_REGS-1:0]  set_mask_p0;

  rr_arbiter_2 #(
    .RR_ENABLE (RR_ENABLE)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .enable (wb_enable),
    .req_a  (a_valid),
    .req_b  (b_valid),
    .gnt_a  (a_ready),
    .gnt_b  (b_ready)
  );

  // Stage p0: select the granted write and build scoreboard masks.
  always_comb begin
    wr_vld_p0   = a_ready || b_ready;
    wr_dest_p0  = a_dest;
    wr_data_p0  = a_data;
    if (b_ready) begin
      wr_dest_p0 = b_dest;
      wr_data_p0 = b_data;
    end
    clr_mask_p0 = '0;
    if (wr_vld_p0) clr_mask_p0 = IDX_ONE << wr_dest_p0;
    set_mask_p0 = '0;
    if (issue_valid) set_mask_p0 = IDX_ONE << issue_dest;
  end

  // Stage p1: register-file write port and scoreboard; set is applied after clear so it wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_load_enable <= 1'b0;
      rf_port_c      <= '0;
      rf_dest        <= '0;
      busy           <= '0;
    end else begin
      rf_load_enable <= wr_vld_p0;
      if (wr_vld_p0) begin
        rf_port_c <= wr_data_p0;
        rf_dest   <= wr_dest_p0;
      end
      busy <= (busy & ~clr_mask_p0) | set_mask_p0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: round-robin and fixed-priority instances driven in parallel.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_enable;
  logic        a_valid, b_valid, issue_valid;
  logic [3:0]  a_dest, b_dest, issue_dest;
  logic [31:0] a_data, b_data;

  logic        rr_a_ready, rr_b_ready, rr_load;
  logic [31:0] rr_port_c;
  logic [3:0]  rr_dest;
  logic [15:0] rr_busy;

  logic        fp_a_ready, fp_b_ready, fp_load;
  logic [31:0] fp_port_c;
  logic [3:0]  fp_dest;
  logic [15:0] fp_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.RR_ENABLE(1'b1)) u_rr (
    .clk(clk), .reset(reset), .wb_enable(wb_enable),
    .a_valid(a_valid), .a_ready(rr_a_ready), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(rr_b_ready), .b_dest(b_dest), .b_data(b_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .rf_port_c(rr_port_c), .rf_dest(rr_dest), .rf_load_enable(rr_load), .busy(rr_busy)
  );

  regfile_wb_arbiter #(.RR_ENABLE(1'b0)) u_fp (
    .clk(clk), .reset(reset), .wb_enable(wb_enable),
    .a_valid(a_valid), .a_ready(fp_a_ready), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(fp_b_ready), .b_dest(b_dest), .b_data(b_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .rf_port_c(fp_port_c), .rf_dest(fp_dest), .rf_load_enable(fp_load), .busy(fp_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_edge();
    @(negedge clk);
  endtask

  task automatic after_posedge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wb_enable = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
    a_dest = '0; b_dest = '0; issue_dest = '0; a_data = '0; b_data = '0;

    // Reset state, and readies held low during reset even with requests present
    drive_edge();
    wb_enable = 1'b1; a_valid = 1'b1; b_valid = 1'b1; issue_valid = 1'b1; issue_dest = 4'd9;
    #1;
    chk("rst_a_ready", {31'd0, rr_a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, rr_b_ready}, 32'd0);
    after_posedge();
    chk("rst_load", {31'd0, rr_load}, 32'd0);
    chk("rst_busy", {16'd0, rr_busy}, 32'd0);
    chk("rst_dest", {28'd0, rr_dest}, 32'd0);
    chk("rst_port_c", rr_port_c, 32'd0);

    drive_edge();
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;

    // Single A write, 1-cycle latency
    drive_edge();
    a_valid = 1'b1; a_dest = 4'd3; a_data = 32'hDEADBEEF;
    #1;
    chk("t1_a_ready", {31'd0, rr_a_ready}, 32'd1);
    chk("t1_b_ready", {31'd0, rr_b_ready}, 32'd0);
    after_posedge();
    chk("t1_load", {31'd0, rr_load}, 32'd1);
    chk("t1_dest", {28'd0, rr_dest}, 32'd3);
    chk("t1_port_c", rr_port_c, 32'hDEADBEEF);
    drive_edge();
    a_valid = 1'b0;
    after_posedge();
    chk("t1_idle_load", {31'd0, rr_load}, 32'd0);
    chk("t1_hold_dest", {28'd0, rr_dest}, 32'd3);
    chk("t1_hold_port_c", rr_port_c, 32'hDEADBEEF);

    // Lone B write; round-robin state returns to favouring A
    drive_edge();
    b_valid = 1'b1; b_dest = 4'd7; b_data = 32'h0000_1111;
    #1;
    chk("t2_b_ready", {31'd0, rr_b_ready}, 32'd1);
    chk("t2_fp_b_ready", {31'd0, fp_b_ready}, 32'd1);
    after_posedge();
    chk("t2_dest", {28'd0, rr_dest}, 32'd7);
    chk("t2_port_c", rr_port_c, 32'h0000_1111);

    // Contention for 4 cycles: RR alternates A,B,A,B; fixed priority always A
    a_dest = 4'd1; a_data = 32'h0000_00A1; b_dest = 4'd2; b_data = 32'h0000_00B2;
    for (int k = 0; k < 4; k++) begin
      drive_edge();
      a_valid = 1'b1; b_valid = 1'b1;
      #1;
      chk($sformatf("rr_a_ready_%0d", k), {31'd0, rr_a_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_b_ready_%0d", k), {31'd0, rr_b_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("fp_a_ready_%0d", k), {31'd0, fp_a_ready}, 32'd1);
      chk($sformatf("fp_b_ready_%0d", k), {31'd0, fp_b_ready}, 32'd0);
      after_posedge();
      chk($sformatf("rr_dest_%0d", k), {28'd0, rr_dest}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr_port_c_%0d", k), rr_port_c, (k % 2 == 0) ? 32'hA1 : 32'hB2);
      chk($sformatf("rr_load_%0d", k), {31'd0, rr_load}, 32'd1);
      chk($sformatf("fp_dest_%0d", k), {28'd0, fp_dest}, 32'd1);
    end

    // Scoreboard: set on issue, set wins over same-edge clear
    drive_edge();
    a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b1; issue_dest = 4'd5;
    after_posedge();
    chk("sb_set5", {16'd0, rr_busy}, 32'h0020);
    chk("sb_set5_fp", {16'd0, fp_busy}, 32'h0020);
    drive_edge();
    b_valid = 1'b1; b_dest = 4'd5; b_data = 32'h0000_0055;
    #1;
    chk("sb_b5_ready", {31'd0, rr_b_ready}, 32'd1);
    after_posedge();
    chk("sb_set_wins", {16'd0, rr_busy}, 32'h0020);
    chk("sb_b5_dest", {28'd0, rr_dest}, 32'd5);
    chk("sb_b5_load", {31'd0, rr_load}, 32'd1);

    // Clear by A write to 5
    drive_edge();
    b_valid = 1'b0; issue_valid = 1'b0; a_valid = 1'b1; a_dest = 4'd5; a_data = 32'h0000_0005;
    after_posedge();
    chk("sb_clear5", {16'd0, rr_busy}, 32'h0000);

    // Write to non-busy index 9 while issuing 8: write happens, only bit 8 set
    drive_edge();
    a_valid = 1'b0; b_valid = 1'b1; b_dest = 4'd9; b_data = 32'h0000_0099;
    issue_valid = 1'b1; issue_dest = 4'd8;
    after_posedge();
    chk("sb_nonbusy_load", {31'd0, rr_load}, 32'd1);
    chk("sb_nonbusy_dest", {28'd0, rr_dest}, 32'd9);
    chk("sb_nonbusy_busy", {16'd0, rr_busy}, 32'h0100);

    // wb_enable low: no grants, issue still sets busy
    drive_edge();
    wb_enable = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_dest = 4'd4; a_data = 32'h0000_0044; b_dest = 4'd6; b_data = 32'h0000_0066;
    issue_valid = 1'b1; issue_dest = 4'd2;
    #1;
    chk("wben0_a_ready", {31'd0, rr_a_ready}, 32'd0);
    chk("wben0_b_ready", {31'd0, rr_b_ready}, 32'd0);
    after_posedge();
    chk("wben0_load", {31'd0, rr_load}, 32'd0);
    chk("wben0_busy", {16'd0, rr_busy}, 32'h0104);
    drive_edge();
    issue_valid = 1'b0;
    after_posedge();
    chk("wben0_load2", {31'd0, rr_load}, 32'd0);
    chk("wben0_hold_dest", {28'd0, rr_dest}, 32'd9);

    // Raise wb_enable: A first, then B on the RR instance
    drive_edge();
    wb_enable = 1'b1;
    #1;
    chk("wben1_a_ready", {31'd0, rr_a_ready}, 32'd1);
    chk("wben1_b_ready", {31'd0, rr_b_ready}, 32'd0);
    after_posedge();
    chk("wben1_dest", {28'd0, rr_dest}, 32'd4);
    chk("wben1_port_c", rr_port_c, 32'h0000_0044);
    drive_edge();
    #1;
    chk("wben1_b_next", {31'd0, rr_b_ready}, 32'd1);
    chk("wben1_fp_a_next", {31'd0, fp_a_ready}, 32'd1);
    after_posedge();
    chk("wben1_dest2", {28'd0, rr_dest}, 32'd6);
    chk("wben1_fp_dest2", {28'd0, fp_dest}, 32'd4);

    // Handshake, then asynchronous reset before the strobe cycle ends
    drive_edge();
    #1;
    chk("mid_a_ready", {31'd0, rr_a_ready}, 32'd1);
    after_posedge();
    chk("mid_load_before", {31'd0, rr_load}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_load", {31'd0, rr_load}, 32'd0);
    chk("mid_rst_busy", {16'd0, rr_busy}, 32'h0000);
    chk("mid_rst_dest", {28'd0, rr_dest}, 32'd0);
    chk("mid_rst_a_ready", {31'd0, rr_a_ready}, 32'd0);
    drive_edge();
    reset = 1'b0;
    #1;
    chk("post_rst_a_ready", {31'd0, rr_a_ready}, 32'd1);
    chk("post_rst_b_ready", {31'd0, rr_b_ready}, 32'd0);
    after_posedge();
    chk("post_rst_dest", {28'd0, rr_dest}, 32'd4);
    chk("post_rst_load", {31'd0, rr_load}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
